// File: rtl/ram_stream_reader.sv
// Streams a burst of words out of a synchronous-read RAM onto a valid/ready
// stream, then pulses done. The RAM is handed back to writers while idle.
module ram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_en,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  last_c;
  logic                  handshake_c;

  assign last_c      = (cnt_q == CNT_WIDTH'(1));
  assign handshake_c = (state == STREAM) && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Current read address and remaining word count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            addr_q <= base_addr;
            cnt_q  <= len;
          end
        end
        STREAM: begin
          if (handshake_c) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
            if (!last_c) begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? FINISH : PRIME;
        end
      end
      PRIME:  state_next = STREAM;
      STREAM: begin
        if (handshake_c && last_c) begin
          state_next = FINISH;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; the RAM address is presented one edge ahead of the data it selects
  always_comb begin
    ram_en        = 1'b1;
    ram_read_addr = addr_q;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE:   busy = 1'b0;
      PRIME:  ram_en = 1'b1;
      STREAM: begin
        out_valid = 1'b1;
        out_last  = last_c;
        ram_en    = out_ready && !last_c;
        if (out_ready && !last_c) begin
          ram_read_addr = addr_q + ADDR_WIDTH'(1);
        end
      end
      FINISH: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign out_data = ram_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM plus a queue-based model of
// each burst (expected words = mem[(base+i) mod depth]).
module tb_ram_stream_reader;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] ram_read_addr;
  logic          ram_en;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ram_areg;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .ram_read_addr(ram_read_addr), .ram_en(ram_en), .ram_q(ram_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: address register gated by ram_en
  always @(posedge clk) begin
    if (ram_en) ram_areg <= ram_read_addr;
  end
  assign ram_q = mem[ram_areg];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: ready from pat, then 1
  task automatic run_burst(input int unsigned base, input int unsigned n, input int mode,
                           input logic [15:0] pat, input bit poke);
    logic [DW-1:0] exp_w[$];
    int unsigned idx;
    int cyc;
    bit hs;
    for (int unsigned i = 0; i < n; i++) exp_w.push_back(mem[(base + i) % DEPTH]);
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_valid", 32'(out_valid), 32'(0));
    start = 1'b1;
    base_addr = AW'(base);
    len = (AW + 1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      check("zero_done", 32'(done), 32'(1));
      check("zero_busy", 32'(busy), 32'(1));
      check("zero_valid", 32'(out_valid), 32'(0));
      @(posedge clk); #1;
      check("zero_done_end", 32'(done), 32'(0));
      check("zero_busy_end", 32'(busy), 32'(0));
      check("zero_valid_end", 32'(out_valid), 32'(0));
      return;
    end
    check("prime_valid", 32'(out_valid), 32'(0));
    check("prime_busy", 32'(busy), 32'(1));
    check("prime_addr", 32'(ram_read_addr), 32'(base % DEPTH));
    check("prime_en", 32'(ram_en), 32'(1));
    @(posedge clk); #1;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = (cyc < 16) ? pat[cyc] : 1'b1;
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        base_addr = AW'($urandom);
        len = (AW + 1)'($urandom_range(0, 8));
      end
      #1;
      check("valid", 32'(out_valid), 32'(1));
      check("data", 32'(out_data), 32'(exp_w[idx]));
      check("last", 32'(out_last), 32'(idx == n - 1));
      check("ram_en", 32'(ram_en), 32'(out_ready && (idx != n - 1)));
      check("done_mid", 32'(done), 32'(0));
      hs = out_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    start = 1'b0;
    if (idx < n) check("burst_timeout", 32'(idx), 32'(n));
    check("fin_done", 32'(done), 32'(1));
    check("fin_busy", 32'(busy), 32'(1));
    check("fin_valid", 32'(out_valid), 32'(0));
    check("fin_en", 32'(ram_en), 32'(1));
    @(posedge clk); #1;
    check("post_done", 32'(done), 32'(0));
    check("post_busy", 32'(busy), 32'(0));
    check("post_valid", 32'(out_valid), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    int unsigned n;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    #22;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_last", 32'(out_last), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_addr", 32'(ram_read_addr), 32'(0));
    check("rst_en", 32'(ram_en), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_burst(5, 4, 0, 16'h0, 1'b0);
    run_burst(126, 4, 0, 16'h0, 1'b0);
    run_burst(10, 3, 2, 16'b11001, 1'b0);
    run_burst(33, 0, 0, 16'h0, 1'b0);
    run_burst(127, 3, 0, 16'h0, 1'b0);
    run_burst(20, 5, 1, 16'h0, 1'b1);
    run_burst(37, 128, 0, 16'h0, 1'b0);

    // Reset during the second word of a 6-word burst
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(40);
    len = (AW + 1)'(6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_word1", 32'(out_data), 32'(41));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_done", 32'(done), 32'(0));
    check("rst_mid_last", 32'(out_last), 32'(0));
    check("rst_mid_addr", 32'(ram_read_addr), 32'(0));
    check("rst_mid_en", 32'(ram_en), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(out_valid), 32'(0));
    check("post_rst_done", 32'(done), 32'(0));
    run_burst(0, 2, 0, 16'h0, 1'b0);

    // Randomised contents and bursts
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int t = 0; t < 30; t++) begin
      b = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = DEPTH;
        default: n = $urandom_range(1, 20);
      endcase
      run_burst(b, n, 1, 16'h0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
